// File: rtl/rc4_cipher_loopback_if.sv
// Port bundle between the RC4 core (master) and its ciphertext capture/replay buffer (slave).
// Signal names follow the core's cipher port naming.
interface rc4_cipher_loopback_if #(
  parameter int unsigned AW = 11
) ();
  logic          cipher_write;
  logic [7:0]    cipher_out;
  logic          cipher_read;
  logic [7:0]    cipher_in;
  logic          cipher_in_valid;
  logic          replay_en;
  logic          clear;
  logic [AW:0]   byte_count;
  logic          replay_done;
  logic          err;

  modport master (
    output cipher_write, cipher_out, cipher_read, replay_en, clear,
    input  cipher_in, cipher_in_valid, byte_count, replay_done, err
  );

  modport slave (
    input  cipher_write, cipher_out, cipher_read, replay_en, clear,
    output cipher_in, cipher_in_valid, byte_count, replay_done, err
  );
endinterface

// File: rtl/rc4_cipher_loopback.sv
// Captures the ciphertext bytes written by the RC4 core, then replays them in order on request
// so the core can decrypt its own output. Signals end-of-stream once the stored bytes run out.
module rc4_cipher_loopback #(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned AW    = 11
) (
  input logic                  clk,
  input logic                  rst,
  rc4_cipher_loopback_if.slave bus
);

  typedef enum logic [1:0] {StCapture, StReplay, StDrained} state_e;

  localparam logic [AW:0] PtrFull = (AW + 1)'(DEPTH);
  localparam logic [AW:0] PtrOne  = (AW + 1)'(1);

  state_e      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  cin_q, cin_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        mem_we;

  logic [7:0] mem_q [DEPTH];

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cin_d    = cin_q;
    valid_d  = valid_q;
    done_d   = done_q;
    err_d    = err_q;
    mem_we   = 1'b0;

    unique case (state_q)
      StCapture: begin
        if (bus.cipher_write) begin
          if (wr_ptr_q != PtrFull) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PtrOne;
          end else begin
            err_d = 1'b1;
          end
        end
        if (bus.replay_en) begin
          state_d = StReplay;
        end
      end
      StReplay: begin
        // A write wins over a simultaneous read; the read is dropped.
        if (bus.cipher_write) begin
          err_d = 1'b1;
        end else if (bus.cipher_read) begin
          if (rd_ptr_q != wr_ptr_q) begin
            cin_d    = mem_q[rd_ptr_q[AW-1:0]];
            valid_d  = 1'b1;
            rd_ptr_d = rd_ptr_q + PtrOne;
          end else begin
            cin_d   = 8'h00;
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = StDrained;
          end
        end
      end
      StDrained: begin
        if (bus.cipher_write) begin
          err_d = 1'b1;
        end else if (bus.cipher_read) begin
          cin_d   = 8'h00;
          valid_d = 1'b0;
        end
      end
      default: state_d = StCapture;
    endcase

    // Clear acts like reset but leaves the stored bytes in place.
    if (bus.clear) begin
      state_d  = StCapture;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cin_d    = 8'h00;
      valid_d  = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      mem_we   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StCapture;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cin_q    <= 8'h00;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cin_q    <= cin_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.cipher_out;
    end
  end

  assign bus.cipher_in       = cin_q;
  assign bus.cipher_in_valid = valid_q;
  assign bus.byte_count      = wr_ptr_q;
  assign bus.replay_done     = done_q;
  assign bus.err             = err_q;

endmodule

// File: doc/rc4_cipher_loopback.md
# rc4_cipher_loopback

Capture-and-replay byte buffer sitting between the RC4 core's cipher output port and its cipher input port. During encryption it stores every byte the core writes on `cipher_write`/`cipher_out`. Once replay is enabled, it returns those bytes in order on `cipher_in`/`cipher_in_valid` in response to `cipher_read`, so the core can decrypt its own ciphertext. When the stored stream is exhausted it signals end-of-stream.

## Interface
Parameters:
- `DEPTH`, 2048: byte capacity; must be a power of two.
- `AW`, 11: address width, log2(`DEPTH`).

Ports:
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `cipher_write`  in  1  core strobe: `cipher_out` is valid this cycle.
- `cipher_out`  in  8  ciphertext byte from the core.
- `cipher_read`  in  1  core request for the next ciphertext byte.
- `cipher_in`  out  8  replayed byte, registered.
- `cipher_in_valid`  out  1  1 = `cipher_in` holds a stored byte; 0 = end of stream.
- `replay_en`  in  1  level; moves the block from capture to replay.
- `clear`  in  1  one-cycle pulse; empties the buffer and returns to CAPTURE.
- `byte_count`  out  AW+1  number of bytes captured, range 0..`DEPTH`.
- `replay_done`  out  1  sticky; set when a read finds the stream exhausted.
- `err`  out  1  sticky; overflow or a write arriving outside CAPTURE.

## Operation
- Storage is a `DEPTH`x8 array addressed by `wr_ptr` and `rd_ptr`, both AW+1 bits wide. `byte_count` equals `wr_ptr`.
- The FSM has three states: CAPTURE (entered on reset), REPLAY and DRAINED.
- CAPTURE:
  - `cipher_write`=1 and `wr_ptr`<`DEPTH`: store `cipher_out` at `mem[wr_ptr]`, then `wr_ptr`++.
  - `cipher_write`=1 and `wr_ptr`==`DEPTH`: drop the byte and set `err`=1.
  - `cipher_read` is ignored; outputs hold.
  - `replay_en`=1 moves the FSM to REPLAY on the next edge. A write in that same cycle is still captured.
- REPLAY:
  - A request is `cipher_read`=1 and `cipher_write`=0. If both are high, the write has priority, the read is ignored and `err`=1.
  - Request with `rd_ptr`<`wr_ptr`: `cipher_in`<=`mem[rd_ptr]`, `cipher_in_valid`<=1, `rd_ptr`++.
  - Request with `rd_ptr`==`wr_ptr`: `cipher_in`<=0x00, `cipher_in_valid`<=0, `replay_done`<=1, and the FSM moves to DRAINED.
  - With no request, `cipher_in` and `cipher_in_valid` hold their last values.
- DRAINED: every request gives `cipher_in`=0x00 and `cipher_in_valid`=0. A write sets `err`.
- `replay_en` falling has no effect after the block has left CAPTURE.
- `clear` works from any state and is applied like `rst`, except that memory contents are not cleared. `clear` has priority over all other inputs in that cycle.

## Timing
- Reset values: `cipher_in`=0x00, `cipher_in_valid`=0, `byte_count`=0, `replay_done`=0, `err`=0. Pointers are 0 and the FSM is in CAPTURE. Memory is not initialised.
- Write latency: a byte presented at rising edge N is stored at N. `byte_count` shows the new value after N.
- Read latency: a request sampled at rising edge N drives `cipher_in`/`cipher_in_valid` after N, so they are stable for the core to sample at edge N+1.
- Back-to-back requests on consecutive cycles return consecutive bytes with no bubbles.
- Memory read is synchronous, one port per direction. Same-address read and write cannot occur, because writes are only accepted in CAPTURE.
- Pointer wrap cannot happen: `wr_ptr` saturates at `DEPTH`, and `rd_ptr` never passes `wr_ptr`.
- `rst` or `clear` asserted mid-replay: on the next edge all outputs return to reset values and any request in that cycle is discarded.

## Test plan
- Capture then replay: write 0x11,0x22,0x33; raise `replay_en`; issue 4 reads. Expect `cipher_in`=0x11,0x22,0x33 with valid=1, then 0x00 with valid=0. `replay_done`=1, `byte_count`=3, `err`=0.
- Overflow: write `DEPTH`+1 bytes with value = index mod 256. Expect `byte_count`=2048 and `err`=1. Replay returns exactly 2048 valid bytes, 0x00..0xFF repeating, followed by valid=0.
- Read/write collision in REPLAY: assert `cipher_read`=1 and `cipher_write`=1 together. Expect outputs unchanged, `rd_ptr` unchanged, `err`=1.
- Empty replay: raise `replay_en` with no writes, then issue one read. Expect valid=0, `cipher_in`=0x00, `replay_done`=1.
- Reads during CAPTURE: read 5 times before `replay_en`. Expect outputs held at reset values. A later replay still starts at byte 0.
- Clear mid-replay: replay 2 of 4 bytes, pulse `clear`, write 0xAA, enable replay, read twice. Expect 0xAA with valid=1, then valid=0, and `byte_count`=1.
